syn_lb_arb: RTL
===============

# syn_lb_arb

Round-robin arbiter that shares one local-bus (syn_lb) slave segment between NUM_REQ host-side requesters. It serialises single read/write transactions onto the shared master port, routes read data back to the winning requester, and recovers from a slave that never answers a read by returning a fixed error word after a timeout. It sits between the host bridges and the local-bus register decoder.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, bus data width
- ADDR_W, 8, bus address width
- TIMEOUT_CYC, 64, maximum read-wait cycles (≥1)
- TIMEOUT_DATA, 32'hDEAD_BEEF (DATA_W wide), read data returned on timeout

Ports (one clock; reset is asynchronous and active-low):
- clk_ir  in  1  system clock
- rst_il  in  1  async active-low reset
- req_rd_en  in  NUM_REQ  per-requester read request, level, held until ack
- req_wr_en  in  NUM_REQ  per-requester write request, level, held until ack
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wr_data  in  NUM_REQ*DATA_W  packed write data, same packing
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- rsp_rd_valid  out  NUM_REQ  one-cycle read-data strobe, one-hot
- rsp_rd_data  out  DATA_W  read data, shared, valid with rsp_rd_valid
- lb_rd_en, lb_wr_en, lb_wr_valid  out  1  shared bus strobes
- lb_addr  out  ADDR_W  shared bus address
- lb_wr_data  out  DATA_W  shared bus write data
- lb_rd_valid  in  1  slave read-data strobe
- lb_rd_data  in  DATA_W  slave read data
- rd_timeout  out  1  one-cycle pulse when a read times out
- busy  out  1  high whenever the FSM is not IDLE
- gnt_id  out  clog2(NUM_REQ)  index of current/last winner

## Operation
- All outputs are registered. Reset value of every output is 0. State=IDLE, rr_ptr=NUM_REQ-1, timeout counter=0.
- A requester is pending if req_rd_en[i] or req_wr_en[i]. If both are set, the write is served and the read stays pending.
- FSM states:
  - IDLE: if any request is pending, choose the first pending index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. Latch index, type, addr and wr_data. Set rr_ptr=winner and go to ISSUE. With no request pending, stay in IDLE.
  - ISSUE (1 cycle):
    - Write: lb_wr_en=lb_wr_valid=1 with lb_addr/lb_wr_data, req_ack[winner]=1, next state IDLE.
    - Read: lb_rd_en=1 with lb_addr, next state WAIT_RD with counter=0.
  - WAIT_RD: each cycle without lb_rd_valid, counter increments.
    - On lb_rd_valid: capture lb_rd_data. Next cycle rsp_rd_valid[winner]=req_ack[winner]=1 with rsp_rd_data=captured data. Then IDLE.
    - If counter==TIMEOUT_CYC-1 and lb_rd_valid=0: next cycle rsp_rd_data=TIMEOUT_DATA, rsp_rd_valid[winner]=req_ack[winner]=1, rd_timeout=1. Then IDLE.
    - lb_rd_valid in the expiry cycle wins: real data is returned and there is no timeout.
  - RESP (1 cycle): drives the response pulses listed above, then IDLE.
- lb_rd_valid outside WAIT_RD is ignored.
- lb strobes are low in every state except ISSUE. lb_addr/lb_wr_data hold their last values.
- A request that is withdrawn before the arbiter samples it in IDLE is never issued. Once latched, the transaction completes regardless of request level.
- Reset asserted mid-transaction aborts immediately: no ack, all outputs 0, rr_ptr back to NUM_REQ-1.

## Timing
- Write: request sampled in IDLE at cycle 0. lb_wr_en and req_ack are high in cycle 1. IDLE again in cycle 2. Back-to-back writes run at one per 2 cycles.
- Read: lb_rd_en in cycle 1. WAIT_RD starts in cycle 2. lb_rd_valid in cycle k (k≥2) gives rsp_rd_valid/req_ack in cycle k+1 and IDLE in cycle k+2.
- Timeout: with no lb_rd_valid, WAIT_RD lasts exactly TIMEOUT_CYC cycles (cycles 2..TIMEOUT_CYC+1). Response and rd_timeout occur in cycle TIMEOUT_CYC+2.
- Requesters deassert their request in the cycle after req_ack. The arbiter's IDLE cycle follows ack, so the served request is never re-granted.
- Fairness: with all requesters continuously pending, grants rotate 0,1,…,NUM_REQ-1,0,…

## Test plan
- Single write: req 2 writes addr 0x10, data 0x12345678 -> lb_wr_en in cycle 1 with those values, req_ack=4'b0100 in cycle 1, busy low in cycle 2.
- Read with latency 3: req 1 reads 0x20, slave returns 0xCAFEF00D 3 cycles after lb_rd_en -> rsp_rd_valid=4'b0010 with 0xCAFEF00D one cycle later, rd_timeout stays 0.
- Round robin: all 4 requesters write continuously from reset -> grant order 0,1,2,3,0, each 2 cycles apart.
- Timeout: req 3 reads, slave silent -> after 64 WAIT_RD cycles, rsp_rd_data=0xDEADBEEF, rd_timeout=1, req_ack=4'b1000. A later lb_rd_valid is ignored.
- Boundary: lb_rd_valid in the 64th WAIT_RD cycle -> real data returned, no timeout. Requester with both rd and wr set -> write first, read on its next grant.
- Reset mid-read: rst_il low during WAIT_RD -> all outputs 0 immediately, no ack. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/syn_lb_arb_if.sv
// Shared local-bus (syn_lb) segment between the arbiter and the register decoder.
// The arbiter is the master; the decoder answers reads as the slave.
interface syn_lb_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              lb_rd_en;
    logic              lb_wr_en;
    logic              lb_wr_valid;
    logic [ADDR_W-1:0] lb_addr;
    logic [DATA_W-1:0] lb_wr_data;
    logic              lb_rd_valid;
    logic [DATA_W-1:0] lb_rd_data;

    modport master (
        output lb_rd_en, lb_wr_en, lb_wr_valid, lb_addr, lb_wr_data,
        input  lb_rd_valid, lb_rd_data
    );

    modport slave (
        input  lb_rd_en, lb_wr_en, lb_wr_valid, lb_addr, lb_wr_data,
        output lb_rd_valid, lb_rd_data
    );
endinterface

// File: rtl/syn_lb_arb.sv
// Round-robin arbiter serialising single read/write transactions from NUM_REQ
// host requesters onto one syn_lb slave segment, with a read-response timeout.
module syn_lb_arb #(
    parameter int                NUM_REQ      = 4,
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 8,
    parameter int                TIMEOUT_CYC  = 64,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF),
    localparam int               ID_W         = $clog2(NUM_REQ)
) (
    input  logic                       clk_ir,
    input  logic                       rst_il,
    input  logic [NUM_REQ-1:0]         req_rd_en,
    input  logic [NUM_REQ-1:0]         req_wr_en,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wr_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         rsp_rd_valid,
    output logic [DATA_W-1:0]          rsp_rd_data,
    output logic                       rd_timeout,
    output logic                       busy,
    output logic [ID_W-1:0]            gnt_id,
    syn_lb_arb_if.master               lb
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_RESP
    } state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                win_wr, win_wr_n;
    logic [ID_W-1:0]     gnt_id_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wdata_n;
    logic [DATA_W-1:0]   rdata_n;
    logic [NUM_REQ-1:0]  ack_n, rv_n;
    logic                to_n, rd_en_n, wr_en_n;

    logic [NUM_REQ-1:0]  pending;
    logic                grant_found;
    logic [ID_W-1:0]     grant_id;

    assign pending = req_rd_en | req_wr_en;

    // First pending requester strictly after the last winner, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!grant_found && pending[(int'(rr_ptr) + off) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
            end
        end
    end

    // Every output is registered, so the comb block computes next-cycle values.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_n  = state;
        rr_ptr_n = rr_ptr;
        cnt_n    = cnt;
        win_wr_n = win_wr;
        gnt_id_n = gnt_id;
        addr_n   = lb.lb_addr;
        wdata_n  = lb.lb_wr_data;
        rdata_n  = rsp_rd_data;
        ack_n    = '0;
        rv_n     = '0;
        to_n     = 1'b0;
        rd_en_n  = 1'b0;
        wr_en_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    state_n  = S_ISSUE;
                    rr_ptr_n = grant_id;
                    gnt_id_n = grant_id;
                    win_wr_n = req_wr_en[grant_id];
                    addr_n   = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
                    wdata_n  = req_wr_data[int'(grant_id)*DATA_W +: DATA_W];
                    wr_en_n  = req_wr_en[grant_id];
                    rd_en_n  = !req_wr_en[grant_id];
                    // A write completes on the bus strobe itself, so ack rides with it.
                    if (req_wr_en[grant_id]) ack_n = NUM_REQ'(1) << grant_id;
                end
            end

            S_ISSUE: begin
                if (win_wr) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_WAIT_RD;
                    cnt_n   = '0;
                end
            end

            S_WAIT_RD: begin
                if (lb.lb_rd_valid) begin
                    state_n = S_RESP;
                    rdata_n = lb.lb_rd_data;
                    ack_n   = NUM_REQ'(1) << gnt_id;
                    rv_n    = NUM_REQ'(1) << gnt_id;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_n = S_RESP;
                    rdata_n = TIMEOUT_DATA;
                    ack_n   = NUM_REQ'(1) << gnt_id;
                    rv_n    = NUM_REQ'(1) << gnt_id;
                    to_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_RESP: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state          <= S_IDLE;
            rr_ptr         <= ID_W'(NUM_REQ - 1);
            cnt            <= '0;
            win_wr         <= 1'b0;
            gnt_id         <= '0;
            req_ack        <= '0;
            rsp_rd_valid   <= '0;
            rsp_rd_data    <= '0;
            rd_timeout     <= 1'b0;
            busy           <= 1'b0;
            lb.lb_rd_en    <= 1'b0;
            lb.lb_wr_en    <= 1'b0;
            lb.lb_wr_valid <= 1'b0;
            lb.lb_addr     <= '0;
            lb.lb_wr_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state          <= state_n;
            rr_ptr         <= rr_ptr_n;
            cnt            <= cnt_n;
            win_wr         <= win_wr_n;
            gnt_id         <= gnt_id_n;
            req_ack        <= ack_n;
            rsp_rd_valid   <= rv_n;
            rsp_rd_data    <= rdata_n;
            rd_timeout     <= to_n;
            busy           <= (state_n != S_IDLE);
            lb.lb_rd_en    <= rd_en_n;
            lb.lb_wr_en    <= wr_en_n;
            lb.lb_wr_valid <= wr_en_n;
            lb.lb_addr     <= addr_n;
            lb.lb_wr_data  <= wdata_n;
        end
    end

endmodule
